// File: rtl/trees_pkg.sv
// ============================================================================
// Module      : trees_pkg
// Description : Shared sizing constants and FSM state encoding for the
//               random-forest vote packer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package trees_pkg;

  localparam int N_TREES  = 128;
  localparam int N_CLASES = 32;
  localparam int CLASS_W  = $clog2(N_CLASES);
  localparam int VOTE_W   = $clog2(N_TREES + 1);

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_SCAN  = 2'd1,
    ST_PACK  = 2'd2,
    ST_OUT   = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/trees_vote_packer_if.sv
// ============================================================================
// Module      : trees_vote_packer_if
// Description : Vote input, flush control and 64-bit DMA beat output bundle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface trees_vote_packer_if #(
  parameter int CLASS_W = trees_pkg::CLASS_W
);

  logic               vote_valid;
  logic               vote_ready;
  logic [CLASS_W-1:0] vote_class;
  logic               vote_last;
  logic               flush;
  logic               flush_done;
  logic               out_valid;
  logic               out_ready;
  logic [63:0]        out_data;

  modport master (
    output vote_valid, vote_class, vote_last, flush, out_ready,
    input  vote_ready, flush_done, out_valid, out_data
  );

  modport slave (
    input  vote_valid, vote_class, vote_last, flush, out_ready,
    output vote_ready, flush_done, out_valid, out_data
  );

endinterface

`default_nettype wire

// File: rtl/trees_vote_counters.sv
// ============================================================================
// Module      : trees_vote_counters
// Description : Per-class saturating vote counters with clear-on-read port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module trees_vote_counters #(
  parameter int N_CLASES = 32,
  parameter int VOTE_W   = 8,
  localparam int CW      = $clog2(N_CLASES)
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              inc_i,
  input  wire logic [CW-1:0]     inc_idx_i,
  input  wire logic [CW-1:0]     rd_idx_i,
  input  wire logic              clr_i,
  output logic      [VOTE_W-1:0] rd_cnt_o
);

  logic [VOTE_W-1:0] cnt_q [N_CLASES];

  // Clear and increment never coincide: votes are only accepted outside SCAN.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_CLASES; i++) begin
        cnt_q[i] <= '0;
      end
    end else if (clr_i) begin
      cnt_q[rd_idx_i] <= '0;
    end else if (inc_i && (cnt_q[inc_idx_i] != '1)) begin
      cnt_q[inc_idx_i] <= cnt_q[inc_idx_i] + 1'b1;
    end
  end

  assign rd_cnt_o = cnt_q[rd_idx_i];

endmodule

`default_nettype wire

// File: rtl/trees_vote_packer.sv
// ============================================================================
// Module      : trees_vote_packer
// Description : Accumulates per-tree votes, picks the argmax class per sample
//               and packs two 32-bit predictions into each 64-bit DMA beat.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module trees_vote_packer #(
  parameter int N_TREES  = 128,
  parameter int N_CLASES = 32
) (
  input wire logic          clk,
  input wire logic          rst,
  trees_vote_packer_if.slave bus
);

  import trees_pkg::*;

  localparam int CW = $clog2(N_CLASES);
  localparam int VW = $clog2(N_TREES + 1);

  state_e        state_q, state_d;
  logic [CW-1:0] idx_q, idx_d;
  logic [CW-1:0] best_idx_q, best_idx_d;
  logic [VW-1:0] best_cnt_q, best_cnt_d;
  logic [31:0]   low_q, low_d;
  logic          low_full_q, low_full_d;
  logic [63:0]   out_data_q, out_data_d;
  logic          vote_ready_q, vote_ready_d;
  logic          flush_done_q, flush_done_d;
  logic          flush_pend_q, flush_pend_d;
  logic          flushing_q, flushing_d;
  logic          active_q, active_d;
  logic          last_q, last_d;

  logic          w_vote_fire;
  logic          w_clr;
  logic [VW-1:0] w_rd_cnt;
  logic [31:0]   w_pred;

  assign w_vote_fire = bus.vote_valid & vote_ready_q;
  assign w_pred      = 32'(best_idx_q);

  trees_vote_counters #(
    .N_CLASES (N_CLASES),
    .VOTE_W   (VW)
  ) u_counters (
    .clk       (clk),
    .rst       (rst),
    .inc_i     (w_vote_fire),
    .inc_idx_i (bus.vote_class),
    .rd_idx_i  (idx_q),
    .clr_i     (w_clr),
    .rd_cnt_o  (w_rd_cnt)
  );

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    best_idx_d   = best_idx_q;
    best_cnt_d   = best_cnt_q;
    low_d        = low_q;
    low_full_d   = low_full_q;
    out_data_d   = out_data_q;
    flush_done_d = 1'b0;
    flush_pend_d = flush_pend_q | bus.flush;
    flushing_d   = flushing_q;
    active_d     = active_q;
    last_d       = last_q;
    w_clr        = 1'b0;

    case (state_q)
      ST_ACCUM: begin
        if (w_vote_fire) begin
          active_d = 1'b1;
          if (bus.vote_last) begin
            last_d = 1'b1;
          end
        end
        if (last_q) begin
          state_d    = ST_SCAN;
          idx_d      = '0;
          best_idx_d = '0;
          best_cnt_d = '0;
          last_d     = 1'b0;
          active_d   = 1'b0;
        end else if (flush_pend_d && !active_q && !w_vote_fire) begin
          // Flush only between samples; a half-filled beat goes out padded.
          if (low_full_q) begin
            out_data_d = {32'h0, low_q};
            flushing_d = 1'b1;
            state_d    = ST_OUT;
          end else begin
            flush_done_d = 1'b1;
            flush_pend_d = 1'b0;
          end
        end
      end

      ST_SCAN: begin
        w_clr = 1'b1;
        if (w_rd_cnt > best_cnt_q) begin
          best_cnt_d = w_rd_cnt;
          best_idx_d = idx_q;
        end
        if (idx_q == CW'(N_CLASES - 1)) begin
          state_d = ST_PACK;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      ST_PACK: begin
        if (!low_full_q) begin
          low_d      = w_pred;
          low_full_d = 1'b1;
          state_d    = ST_ACCUM;
        end else begin
          out_data_d = {w_pred, low_q};
          state_d    = ST_OUT;
        end
      end

      ST_OUT: begin
        if (bus.out_ready) begin
          low_full_d = 1'b0;
          state_d    = ST_ACCUM;
          if (flushing_q) begin
            flushing_d   = 1'b0;
            flush_done_d = 1'b1;
            flush_pend_d = bus.flush;
          end
        end
      end

      default: state_d = ST_ACCUM;
    endcase

    // Hold off votes while a sample closes or an idle flush is about to run.
    vote_ready_d = (state_d == ST_ACCUM) && !last_d && !(flush_pend_d && !active_d);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_ACCUM;
      idx_q        <= '0;
      best_idx_q   <= '0;
      best_cnt_q   <= '0;
      low_q        <= '0;
      low_full_q   <= 1'b0;
      out_data_q   <= '0;
      vote_ready_q <= 1'b0;
      flush_done_q <= 1'b0;
      flush_pend_q <= 1'b0;
      flushing_q   <= 1'b0;
      active_q     <= 1'b0;
      last_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      best_idx_q   <= best_idx_d;
      best_cnt_q   <= best_cnt_d;
      low_q        <= low_d;
      low_full_q   <= low_full_d;
      out_data_q   <= out_data_d;
      vote_ready_q <= vote_ready_d;
      flush_done_q <= flush_done_d;
      flush_pend_q <= flush_pend_d;
      flushing_q   <= flushing_d;
      active_q     <= active_d;
      last_q       <= last_d;
    end
  end

  assign bus.vote_ready = vote_ready_q;
  assign bus.flush_done = flush_done_q;
  assign bus.out_valid  = (state_q == ST_OUT);
  assign bus.out_data   = out_data_q;

endmodule

`default_nettype wire

// File: tb/tb_trees_vote_packer.sv
// ============================================================================
// Module      : tb_trees_vote_packer
// Description : Self-checking bench for trees_vote_packer with a vote-count
//               reference model and randomized vote ordering.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_trees_vote_packer;

  localparam int N_TREES  = 128;
  localparam int N_CLASES = 32;
  localparam int CW       = $clog2(N_CLASES);
  localparam int VW       = $clog2(N_TREES + 1);
  localparam int SAT      = (1 << VW) - 1;
  localparam int LAT      = N_CLASES + 2;

  logic clk;
  logic rst;
  int   cyc;
  int   ov_cycles;
  int   n_checks;
  int   n_err;

  logic        m_low_full;
  logic [31:0] m_low;
  int          t_last;

  trees_vote_packer_if #(.CLASS_W(CW)) bus ();

  trees_vote_packer #(
    .N_TREES  (N_TREES),
    .N_CLASES (N_CLASES)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial ov_cycles = 0;
  always @(negedge clk) if (bus.out_valid === 1'b1) ov_cycles <= ov_cycles + 1;

  // Reference: saturated per-class tallies, lowest index wins ties.
  function automatic int predict(input int ca, input int na, input int cb, input int nb);
    int c [N_CLASES];
    int best;
    foreach (c[i]) c[i] = 0;
    c[ca] += na;
    c[cb] += nb;
    best = 0;
    for (int i = 0; i < N_CLASES; i++) begin
      if (c[i] > SAT) c[i] = SAT;
      if (c[i] > c[best]) best = i;
    end
    return best;
  endfunction

  task automatic send_vote(input int cls, input bit last, input bit bubble_ok, input bit flush_last);
    int g;
    g = 0;
    if (bubble_ok && ($urandom_range(0, 3) == 0)) begin
      bus.vote_valid = 1'b0;
      @(negedge clk);
    end
    bus.vote_valid = 1'b1;
    bus.vote_class = cls[CW-1:0];
    bus.vote_last  = last;
    while ((bus.vote_ready !== 1'b1) && (g < 2000)) begin
      @(negedge clk);
      g++;
    end
    if (g >= 2000) begin
      n_checks++;
      n_err++;
      $display("FAIL vote_accept_timeout: vote_ready=%b required 1", bus.vote_ready);
    end
    if (last && flush_last) bus.flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.vote_valid = 1'b0;
    bus.vote_last  = 1'b0;
    bus.flush      = 1'b0;
    if (last) t_last = cyc;
  endtask

  task automatic run_sample(input int ca, input int na, input int cb, input int nb,
                            input bit keep_first, input bit flush_last,
                            output bit beat_due, output logic [63:0] exp_beat);
    int q[$];
    int j;
    int tmp;
    int pred;
    for (int i = 0; i < na; i++) q.push_back(ca);
    for (int i = 0; i < nb; i++) q.push_back(cb);
    for (int i = q.size() - 1; i > 0; i--) begin
      j = $urandom_range(0, i);
      tmp = q[i]; q[i] = q[j]; q[j] = tmp;
    end
    if (keep_first) begin
      for (int i = 0; i < q.size(); i++) begin
        if (q[i] == ca) begin
          tmp = q[i]; q[i] = q[0]; q[0] = tmp;
          break;
        end
      end
    end
    for (int i = 0; i < q.size(); i++) begin
      send_vote(q[i], i == q.size() - 1, !(keep_first && i == 0), flush_last);
    end
    pred = predict(ca, na, cb, nb);
    exp_beat = '0;
    if (m_low_full) begin
      beat_due   = 1'b1;
      exp_beat   = {32'(pred), m_low};
      m_low_full = 1'b0;
    end else begin
      beat_due   = 1'b0;
      m_low      = 32'(pred);
      m_low_full = 1'b1;
    end
  endtask

  task automatic collect_beat(output logic [63:0] d, output int lat, output bit ok);
    int g;
    g = 0;
    while ((bus.out_valid !== 1'b1) && (g < 500)) begin
      @(negedge clk);
      g++;
    end
    ok  = (g < 500);
    lat = cyc - t_last;
    d   = bus.out_data;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b required 0", bus.out_valid); end
    n_checks++; if (bus.out_data !== 64'h0) begin n_err++; $display("FAIL reset_out_data: got %h required 0", bus.out_data); end
    n_checks++; if (bus.flush_done !== 1'b0) begin n_err++; $display("FAIL reset_flush_done: got %b required 0", bus.flush_done); end
    n_checks++; if (bus.vote_ready !== 1'b0) begin n_err++; $display("FAIL reset_vote_ready: got %b required 0", bus.vote_ready); end
    rst = 1'b1;
    #1;
    n_checks++; if (bus.vote_ready !== 1'b0) begin n_err++; $display("FAIL ready_before_edge: got %b required 0", bus.vote_ready); end
    @(negedge clk);
    n_checks++; if (bus.vote_ready !== 1'b1) begin n_err++; $display("FAIL ready_after_edge: got %b required 1", bus.vote_ready); end
  endtask

  task automatic test_pair_basic();
    bit due; logic [63:0] e; logic [63:0] d; int lat; bit ok;
    run_sample(3, 70, 7, 58, 1'b0, 1'b0, due, e);
    n_checks++; if (bus.out_valid !== 1'b0 || due) begin n_err++; $display("FAIL first_of_pair_no_beat: out_valid=%b required 0", bus.out_valid); end
    run_sample(31, 128, 0, 0, 1'b0, 1'b0, due, e);
    collect_beat(d, lat, ok);
    n_checks++; if (!ok) begin n_err++; $display("FAIL basic_timeout: out_valid never seen, required 1"); end
    n_checks++; if (d !== 64'h0000001F_00000003) begin n_err++; $display("FAIL basic_beat: got %h required %h", d, 64'h0000001F_00000003); end
    n_checks++; if (lat != LAT) begin n_err++; $display("FAIL basic_latency: got %0d required %0d", lat, LAT); end
  endtask

  task automatic test_tie();
    bit due; logic [63:0] e; logic [63:0] d; int lat; bit ok;
    run_sample(5, 64, 2, 64, 1'b0, 1'b0, due, e);
    run_sample(5, 64, 2, 64, 1'b0, 1'b0, due, e);
    collect_beat(d, lat, ok);
    n_checks++; if (!ok || d !== 64'h00000002_00000002) begin n_err++; $display("FAIL tie_beat: got %h required %h", d, 64'h00000002_00000002); end
    n_checks++; if (lat != LAT) begin n_err++; $display("FAIL tie_latency: got %0d required %0d", lat, LAT); end
  endtask

  task automatic test_saturation();
    bit due; logic [63:0] e; logic [63:0] d; int lat; bit ok;
    run_sample(9, 300, 4, 260, 1'b0, 1'b0, due, e);
    run_sample(17, 1, 0, 0, 1'b0, 1'b0, due, e);
    collect_beat(d, lat, ok);
    n_checks++; if (!ok || d !== e) begin n_err++; $display("FAIL saturation_beat: got %h required %h", d, e); end
  endtask

  task automatic test_flush_pair();
    bit due; logic [63:0] e; logic [63:0] d; int lat; bit ok;
    run_sample(1, 40, 9, 30, 1'b0, 1'b0, due, e);
    run_sample(2, 50, 0, 49, 1'b0, 1'b0, due, e);
    collect_beat(d, lat, ok);
    n_checks++; if (!ok || d !== 64'h00000002_00000001) begin n_err++; $display("FAIL flush_pair_beat1: got %h required %h", d, 64'h00000002_00000001); end
    run_sample(4, 60, 31, 10, 1'b0, 1'b1, due, e);
    collect_beat(d, lat, ok);
    m_low_full = 1'b0;
    n_checks++; if (!ok || d !== 64'h00000000_00000004) begin n_err++; $display("FAIL flush_pair_beat2: got %h required %h", d, 64'h00000000_00000004); end
    n_checks++; if (bus.flush_done !== 1'b1) begin n_err++; $display("FAIL flush_done_after_hs: got %b required 1", bus.flush_done); end
    @(negedge clk);
    n_checks++; if (bus.flush_done !== 1'b0) begin n_err++; $display("FAIL flush_done_pulse: got %b required 0", bus.flush_done); end
  endtask

  task automatic test_stall();
    bit due; logic [63:0] e; logic [63:0] d; int lat; bit ok; int g;
    run_sample(3, 40, 9, 10, 1'b0, 1'b0, due, e);
    run_sample(6, 20, 7, 21, 1'b0, 1'b0, due, e);
    g = 0;
    while ((bus.out_valid !== 1'b1) && (g < 500)) begin @(negedge clk); g++; end
    n_checks++; if (g >= 500) begin n_err++; $display("FAIL stall_timeout: out_valid never seen, required 1"); end
    bus.vote_valid = 1'b1;
    bus.vote_class = CW'(12);
    bus.vote_last  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_checks++; if (bus.out_data !== e) begin n_err++; $display("FAIL stall_data_stable: got %h required %h", bus.out_data, e); end
      n_checks++; if (bus.vote_ready !== 1'b0) begin n_err++; $display("FAIL stall_ready_low: got %b required 0", bus.vote_ready); end
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    // Held class-12 vote must be counted, else class 20 would win.
    run_sample(12, 5, 20, 5, 1'b1, 1'b0, due, e);
    run_sample(1, 7, 0, 7, 1'b0, 1'b0, due, e);
    collect_beat(d, lat, ok);
    n_checks++; if (!ok || d !== 64'h00000000_0000000C) begin n_err++; $display("FAIL stall_release_beat: got %h required %h", d, 64'h00000000_0000000C); end
  endtask

  task automatic test_flush_empty();
    int ov0;
    repeat (3) @(negedge clk);
    ov0 = ov_cycles;
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    n_checks++; if (bus.flush_done !== 1'b1) begin n_err++; $display("FAIL flush_empty_done: got %b required 1", bus.flush_done); end
    @(negedge clk);
    n_checks++; if (bus.flush_done !== 1'b0) begin n_err++; $display("FAIL flush_empty_pulse: got %b required 0", bus.flush_done); end
    repeat (5) @(negedge clk);
    n_checks++; if (ov_cycles != ov0) begin n_err++; $display("FAIL flush_empty_no_beat: out_valid cycles %0d required %0d", ov_cycles, ov0); end
  endtask

  task automatic test_random_pairs();
    bit due; logic [63:0] e; logic [63:0] d; int lat; bit ok;
    for (int p = 0; p < 4; p++) begin
      for (int s = 0; s < 2; s++) begin
        run_sample($urandom_range(0, N_CLASES - 1), $urandom_range(1, 80),
                   $urandom_range(0, N_CLASES - 1), $urandom_range(0, 80), 1'b0, 1'b0, due, e);
      end
      collect_beat(d, lat, ok);
      n_checks++; if (!ok || d !== e) begin n_err++; $display("FAIL random_beat_%0d: got %h required %h", p, d, e); end
      n_checks++; if (lat != LAT) begin n_err++; $display("FAIL random_latency_%0d: got %0d required %0d", p, lat, LAT); end
    end
  endtask

  task automatic test_reset_scan();
    bit due; logic [63:0] e; logic [63:0] d; int lat; bit ok;
    run_sample(11, 60, 2, 3, 1'b0, 1'b0, due, e);
    run_sample(6, 120, 8, 1, 1'b0, 1'b0, due, e);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL scan_rst_out_valid: got %b required 0", bus.out_valid); end
    n_checks++; if (bus.out_data !== 64'h0) begin n_err++; $display("FAIL scan_rst_out_data: got %h required 0", bus.out_data); end
    n_checks++; if (bus.flush_done !== 1'b0) begin n_err++; $display("FAIL scan_rst_flush_done: got %b required 0", bus.flush_done); end
    n_checks++; if (bus.vote_ready !== 1'b0) begin n_err++; $display("FAIL scan_rst_vote_ready: got %b required 0", bus.vote_ready); end
    m_low_full = 1'b0;
    m_low      = '0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_sample(8, 50, 1, 20, 1'b0, 1'b0, due, e);
    n_checks++; if (bus.out_valid !== 1'b0 || due) begin n_err++; $display("FAIL scan_rst_low_cleared: out_valid=%b required 0", bus.out_valid); end
    run_sample(0, 30, 6, 30, 1'b0, 1'b0, due, e);
    collect_beat(d, lat, ok);
    n_checks++; if (!ok || d !== 64'h00000000_00000008) begin n_err++; $display("FAIL scan_rst_beat: got %h required %h", d, 64'h00000000_00000008); end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks       = 0;
    n_err          = 0;
    m_low_full     = 1'b0;
    m_low          = '0;
    t_last         = 0;
    rst            = 1'b0;
    bus.vote_valid = 1'b0;
    bus.vote_class = '0;
    bus.vote_last  = 1'b0;
    bus.flush      = 1'b0;
    bus.out_ready  = 1'b0;

    test_reset();
    test_pair_basic();
    test_tie();
    test_saturation();
    test_flush_pair();
    test_stall();
    test_flush_empty();
    test_random_pairs();
    test_reset_scan();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/trees_vote_packer.md
TREES_VOTE_PACKER -- requirements
Module: trees_vote_packer

Interface
REQ-001 SHALL have parameter N_TREES, default 128, the number of trees voting per sample.
REQ-002 SHALL have parameter N_CLASES, default 32, the number of classes (power of 2, at least 2).
REQ-003 SHALL have port clk  in  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous and active-low.
REQ-005 SHALL have port vote_valid  in  1  a per-tree class vote is presented.
REQ-006 SHALL have port vote_ready  out  1  the block accepts the presented vote.
REQ-007 SHALL have port vote_class  in  $clog2(N_CLASES)  class index voted by one tree.
REQ-008 SHALL have port vote_last  in  1  marks the final vote of the current sample.
REQ-009 SHALL have port flush  in  1  one-cycle pulse: end of batch, emit any half-filled beat.
REQ-010 SHALL have port flush_done  out  1  one-cycle pulse when the flush is complete.
REQ-011 SHALL have port out_valid  out  1  a 64-bit prediction beat is offered to the DMA write channel.
REQ-012 SHALL have port out_ready  in  1  the DMA write channel accepts the beat.
REQ-013 SHALL have port out_data  out  64  beat: [31:0] earlier prediction, [63:32] later prediction.

Function
- REQ-014 A vote SHALL transfer only on a cycle with vote_valid=1 and vote_ready=1, and SHALL increment counter[vote_class].
- REQ-015 The FSM SHALL have states ACCUM, SCAN, PACK and OUT.
- REQ-016 vote_ready SHALL be 1 only in ACCUM with no flush being serviced.
- REQ-017 Each per-class counter SHALL be $clog2(N_TREES+1) bits wide and SHALL saturate at its maximum instead of wrapping.
- REQ-018 When a vote with vote_last=1 transfers, the FSM SHALL go ACCUM->SCAN on the next edge.
- REQ-019 In SCAN, the block SHALL visit one class per cycle, index 0 to N_CLASES-1, taking exactly N_CLASES cycles.
- REQ-020 During SCAN, best SHALL be replaced only on a strictly greater count, so the lowest index wins a tie.
- REQ-021 During SCAN, each visited counter SHALL be cleared.
- REQ-022 After SCAN the FSM SHALL enter PACK; the prediction is the 32-bit zero-extended best index.
- REQ-023 In PACK, if the low half is empty the prediction SHALL go to the low half, the low-half flag SHALL be set, and the FSM SHALL return to ACCUM.
- REQ-024 In PACK, if the low half is occupied, out_data SHALL be loaded with {prediction, low} and the FSM SHALL go to OUT.
- REQ-025 In OUT, out_valid SHALL be 1, and out_data SHALL be held stable until out_ready=1.
- REQ-026 On the OUT handshake, the low-half flag SHALL clear and the FSM SHALL return to ACCUM.
- REQ-027 Latency SHALL be: vote_last accepted at edge t gives out_valid=1 from edge t+N_CLASES+2 (second prediction of a pair).
- REQ-028 flush SHALL be latched in flush_pend and serviced only in ACCUM with zero votes accepted for the current sample.
- REQ-029 A flush arriving mid-sample SHALL wait for that sample's PACK and OUT to finish.
- REQ-030 Servicing a flush with the low half occupied SHALL emit {32'h0, low} via OUT; flush_done SHALL pulse on the cycle after the handshake.
- REQ-031 Servicing a flush with the low half empty SHALL pulse flush_done one cycle later, with no beat emitted.
- REQ-032 flush arriving on the same cycle as a vote_last transfer SHALL be latched, not lost, and serviced after that sample.
- REQ-033 vote_valid is ignored outside ACCUM; upstream SHALL hold the vote until vote_ready=1.

Reset
- REQ-034 While rst=0: state=ACCUM; all counters, best index, low half, low-half flag and flush_pend SHALL be 0.
- REQ-035 While rst=0: out_valid=0, out_data=0, flush_done=0 and vote_ready=0.
- REQ-036 vote_ready SHALL be registered and rise on the first edge after rst deassertion.
- REQ-037 Reset asserted mid-SCAN or mid-OUT SHALL discard the partial sample and any unsent beat.

Structure
- REQ-038 Package trees_pkg SHALL hold N_CLASES, CLASS_W=$clog2(N_CLASES), VOTE_W=$clog2(N_TREES+1) and the FSM state enum.
- REQ-039 The counter array with increment, saturation and clear-on-read SHALL be the sub-module trees_vote_counters.
- REQ-040 The FSM, argmax scan and packing SHALL remain in trees_vote_packer.

Verification
- REQ-041 Bench SHALL cover: sample A (70 votes class 3, 58 class 7), then sample B (128 votes class 31) -> one beat out_data=64'h0000001F_00000003.
- REQ-042 Bench SHALL cover: 64 votes class 5 and 64 votes class 2, twice -> out_data=64'h00000002_00000002 (tie resolves to the lower index).
- REQ-043 Bench SHALL cover: samples predicting 1, 2, 4, then flush -> beats 64'h00000002_00000001 and 64'h00000000_00000004, then flush_done one cycle after the second handshake.
- REQ-044 Bench SHALL cover: out_ready held 0 for 20 cycles with votes pending -> out_data stable, vote_ready=0, and all later votes counted after release.
- REQ-045 Bench SHALL cover: flush with nothing pending -> flush_done one cycle later, out_valid never asserted.
- REQ-046 Bench SHALL cover: rst pulsed low during SCAN -> all outputs 0 immediately; the next full sample pair yields the correct beat with no residual counts.
